demux_1_2_reg: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes: the inverse of the 2:1 select primitive. Each beat accepted on a single input stream is steered to output 0 or output 1. Steering comes either from a per-beat select bit or from an internal alternating pointer. It sits downstream of a shared producer and fans its traffic out to two independent consumers. Each output has its own one-entry holding register, so a stalled consumer never blocks beats destined for the other.

---
 rtl/demux_1_2_reg_if.sv | 32 +++
 rtl/demux_1_2_reg.sv | 77 +++++++
 tb/tb_demux_1_2_reg.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_2_reg_if.sv
// Stream bundle for the 1:2 demux: one input stream and two output streams.
// slave is the demux side; master is the producer/consumer side.
interface demux_1_2_reg_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out0_data, out0_valid,
    input  out0_ready,
    output out1_data, out1_valid,
    input  out1_ready
  );

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out0_data, out0_valid,
    output out0_ready,
    input  out1_data, out1_valid,
    output out1_ready
  );
endinterface

// File: rtl/demux_1_2_reg.sv
// Registered 1:2 stream demux with a one-entry holding register per output,
// steered by in_sel or by an alternating pointer, with per-port delivery counters.
module demux_1_2_reg #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alt_mode,
  demux_1_2_reg_if.slave    bus,
  output logic              rr_ptr,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1
);

  logic             dest;
  logic             free0;
  logic             free1;
  logic             accept;
  logic             load0;
  logic             load1;
  logic             drain0;
  logic             drain1;
  logic [WIDTH-1:0] data0_q;
  logic [WIDTH-1:0] data1_q;
  logic             valid0_q;
  logic             valid1_q;

  // A register draining this cycle counts as free so it refills without a bubble.
  always_comb begin
    dest   = alt_mode ? rr_ptr : bus.in_sel;
    free0  = ~valid0_q | bus.out0_ready;
    free1  = ~valid1_q | bus.out1_ready;
    accept = bus.in_valid & (dest ? free1 : free0);
    load0  = accept & ~dest;
    load1  = accept & dest;
    drain0 = valid0_q & bus.out0_ready;
    drain1 = valid1_q & bus.out1_ready;
  end

  assign bus.in_ready   = dest ? free1 : free0;
  assign bus.out0_data  = data0_q;
  assign bus.out0_valid = valid0_q;
  assign bus.out1_data  = data1_q;
  assign bus.out1_valid = valid1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt0     <= 8'd0;
      cnt1     <= 8'd0;
    end else begin
      if (load0) begin
        data0_q  <= bus.in_data;
        valid0_q <= 1'b1;
      end else if (drain0) begin
        valid0_q <= 1'b0;
      end

      if (load1) begin
        data1_q  <= bus.in_data;
        valid1_q <= 1'b1;
      end else if (drain1) begin
        valid1_q <= 1'b0;
      end

      if (drain0) cnt0 <= cnt0 + 8'd1;
      if (drain1) cnt1 <= cnt1 + 8'd1;

      if (accept && alt_mode) rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Scoreboard bench for demux_1_2_reg: expected beats queue per port on accept,
// popped and compared as each output handshake completes.
module tb_demux_1_2_reg;

  logic       clk;
  logic       rst;
  logic       alt_mode;
  logic       rr_ptr;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  demux_1_2_reg_if #(.WIDTH(8)) bus ();

  demux_1_2_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .alt_mode (alt_mode),
    .bus      (bus),
    .rr_ptr   (rr_ptr),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic       rr_m = 1'b0;
  logic [7:0] c0_m = 8'd0;
  logic [7:0] c1_m = 8'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Outputs are stable at the falling edge; the events decided here happen at the next rising edge.
  always @(negedge clk) begin
    logic d;
    logic exp_rdy;
    chk("out0_valid", bus.out0_valid, q0.size() != 0);
    if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
    chk("out1_valid", bus.out1_valid, q1.size() != 0);
    if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
    chk("rr_ptr", rr_ptr, rr_m);
    chk("cnt0", cnt0, c0_m);
    chk("cnt1", cnt1, c1_m);
    d = alt_mode ? rr_m : bus.in_sel;
    exp_rdy = d ? (q1.size() == 0 || bus.out1_ready) : (q0.size() == 0 || bus.out0_ready);
    chk("in_ready", bus.in_ready, exp_rdy);
    if (rst) begin
      q0.delete(); q1.delete(); got0.delete(); got1.delete();
      rr_m = 1'b0; c0_m = 8'd0; c1_m = 8'd0;
    end else begin
      if (q0.size() != 0 && bus.out0_ready) begin
        got0.push_back(bus.out0_data);
        void'(q0.pop_front());
        c0_m = c0_m + 8'd1;
      end
      if (q1.size() != 0 && bus.out1_ready) begin
        got1.push_back(bus.out1_data);
        void'(q1.pop_front());
        c1_m = c1_m + 8'd1;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (d) q1.push_back(bus.in_data);
        else   q0.push_back(bus.in_data);
        if (alt_mode) rr_m = ~rr_m;
      end
    end
  end

  task automatic send(input logic [7:0] data, input logic sel);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sel   = sel;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    alt_mode = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    bus.in_sel = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset with a beat presented: it must be discarded.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    idle(3);
    chk("rst_v0", bus.out0_valid, 1'b0);
    chk("rst_v1", bus.out1_valid, 1'b0);
    chk("rst_cnt0", cnt0, 8'd0);
    chk("rst_cnt1", cnt1, 8'd0);
    chk("rst_rr", rr_ptr, 1'b0);
    chk("rst_none", got0.size() + got1.size(), 0);

    // Select steering at full rate.
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b0);
    idle(3);
    chk("sel_n0", got0.size(), 2);
    chk("sel_n1", got1.size(), 2);
    if (got0.size() == 2) begin
      chk("sel_o0a", got0[0], 8'h11);
      chk("sel_o0b", got0[1], 8'h44);
    end
    if (got1.size() == 2) begin
      chk("sel_o1a", got1[0], 8'h22);
      chk("sel_o1b", got1[1], 8'h33);
    end
    chk("sel_cnt0", cnt0, 8'd2);
    chk("sel_cnt1", cnt1, 8'd2);

    // Independent back-pressure on out1.
    do_reset(1);
    bus.out1_ready = 1'b0;
    bus.out0_ready = 1'b1;
    send(8'h01, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h02;
    bus.in_sel = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_rdy", bus.in_ready, 1'b0);
      chk("bp_hold1", bus.out1_data, 8'h01);
      @(posedge clk);
      #1;
    end
    send(8'h03, 1'b0);
    idle(2);
    chk("bp_o0_n", got0.size(), 1);
    if (got0.size() == 1) chk("bp_o0", got0[0], 8'h03);
    chk("bp_o1_none", got1.size(), 0);
    bus.out1_ready = 1'b1;
    send(8'h02, 1'b1);
    idle(3);
    chk("bp_o1_n", got1.size(), 2);
    if (got1.size() == 2) begin
      chk("bp_o1a", got1[0], 8'h01);
      chk("bp_o1b", got1[1], 8'h02);
    end
    chk("bp_cnt1", cnt1, 8'd2);

    // Round-robin with a mid-stream stall on out0.
    do_reset(1);
    alt_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out0_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out0_ready = 1'b1;
      end
    join
    idle(4);
    chk("rr_n0", got0.size(), 3);
    chk("rr_n1", got1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got0.size()) chk("rr_o0", got0[i], 8'hA0 + 8'(2 * i));
      if (i < got1.size()) chk("rr_o1", got1[i], 8'hA1 + 8'(2 * i));
    end
    chk("rr_ptr_end", rr_ptr, 1'b0);

    // Drain-and-refill with counter wrap.
    do_reset(1);
    alt_mode = 1'b0;
    for (int i = 0; i < 260; i++) send(8'(i), 1'b0);
    idle(3);
    chk("wrap_n", got0.size(), 260);
    chk("wrap_cnt0", cnt0, 8'd4);
    chk("wrap_cnt1", cnt1, 8'd0);

    // Reset mid-operation with both registers full and stalled.
    do_reset(1);
    alt_mode = 1'b1;
    send(8'h10, 1'b0);
    alt_mode = 1'b0;
    idle(2);
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(8'h5A, 1'b0);
    send(8'hC3, 1'b1);
    idle(1);
    chk("mid_pre_cnt0", cnt0, 8'd1);
    chk("mid_pre_rr", rr_ptr, 1'b1);
    do_reset(1);
    @(negedge clk);
    chk("mid_v0", bus.out0_valid, 1'b0);
    chk("mid_v1", bus.out1_valid, 1'b0);
    chk("mid_cnt0", cnt0, 8'd0);
    chk("mid_cnt1", cnt1, 8'd0);
    chk("mid_rr", rr_ptr, 1'b0);
    @(posedge clk);
    #1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    send(8'h77, 1'b0);
    idle(2);
    chk("mid_after_n", got0.size(), 1);
    if (got0.size() == 1) chk("mid_after", got0[0], 8'h77);
    chk("mid_after_cnt0", cnt0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
